// File: rtl/seg7_scan4.sv
// Four-digit multiplexed seven-segment driver with tear-free, frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan4 #(
    parameter int DIV = 50000,
    parameter int CW  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} scan_t;

    scan_t         state, state_nxt;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          frame_end;

    logic [15:0]   pend_dig, disp_dig;
    logic [3:0]    pend_dp, disp_dp;
    logic          pend_full;

    logic [6:0]    seg_d;
    logic [3:0]    an_d;
    logic          dp_d;
    logic [3:0]    lz;

    assign tick      = (cnt == CW'(DIV - 1));
    assign frame_end = tick && (state == SCAN3);
    assign din_ready = ~pend_full;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b0111111;
            4'd1:    enc = 7'b0000110;
            4'd2:    enc = 7'b1011011;
            4'd3:    enc = 7'b1001111;
            4'd4:    enc = 7'b1100110;
            4'd5:    enc = 7'b1101101;
            4'd6:    enc = 7'b1111101;
            4'd7:    enc = 7'b0000111;
            4'd8:    enc = 7'b1111111;
            4'd9:    enc = 7'b1100111;
            default: enc = 7'b1000000;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (tick) cnt <= '0;
        else cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= SCAN0;
        else state <= state_nxt;
    end

    // NOTE: default assignment first so the combinational process cannot infer a latch.
    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                SCAN0:   state_nxt = SCAN1;
                SCAN1:   state_nxt = SCAN2;
                SCAN2:   state_nxt = SCAN3;
                default: state_nxt = SCAN0;
            endcase
        end
    end

    // Drain only happens when full and accept only when empty, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend_dig  <= '0;
            pend_dp   <= '0;
            disp_dig  <= '0;
            disp_dp   <= '0;
        end else if (frame_end && pend_full) begin
            disp_dig  <= pend_dig;
            disp_dp   <= pend_dp;
            pend_full <= 1'b0;
        end else if (din_valid && !pend_full) begin
            pend_dig  <= din;
            pend_dp   <= dp_in;
            pend_full <= 1'b1;
        end
    end

`ifdef SEG7_LZB_EN
    always_comb begin
        lz    = '0;
        lz[3] = (disp_dig[15:12] == 4'd0) && !disp_dp[3];
        lz[2] = lz[3] && (disp_dig[11:8] == 4'd0) && !disp_dp[2];
        lz[1] = lz[2] && (disp_dig[7:4] == 4'd0) && !disp_dp[1];
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        seg_d = enc(disp_dig[{state, 2'b00} +: 4]);
        an_d  = ~(4'b0001 << state);
        dp_d  = disp_dp[state];
        if (blank || lz[state]) begin
            seg_d = '0;
            an_d  = 4'b1111;
            dp_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= '0;
            an  <= 4'b1111;
            dp  <= 1'b0;
        end else begin
            seg <= seg_d;
            an  <= an_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan4.sv
// Self-checking bench for seg7_scan4 (DIV=4): a frame-timing reference model pushes
// expected outputs into a scoreboard before each edge; they are popped and compared after it.
module tb_seg7_scan4;

    localparam int DIV = 4;
    localparam int CW  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic        din_valid;
    logic        din_ready;
    logic        blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    seg7_scan4 #(.DIV(DIV), .CW(CW)) dut (
        .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .din_valid(din_valid),
        .din_ready(din_ready), .blank(blank), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ready;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference state: position in frame and the display/pending contents.
    int          n;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    bit          m_full;

    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        case (d)
            4'd0: ref_enc = 7'b0111111;  4'd1: ref_enc = 7'b0000110;
            4'd2: ref_enc = 7'b1011011;  4'd3: ref_enc = 7'b1001111;
            4'd4: ref_enc = 7'b1100110;  4'd5: ref_enc = 7'b1101101;
            4'd6: ref_enc = 7'b1111101;  4'd7: ref_enc = 7'b0000111;
            4'd8: ref_enc = 7'b1111111;  4'd9: ref_enc = 7'b1100111;
            default: ref_enc = 7'b1000000;
        endcase
    endfunction

    function automatic bit lead_zero(input int slot);
`ifdef SEG7_LZB_EN
        bit z = (slot != 0);
        for (int j = 1; j < 4; j++)
            if (j >= slot && (m_disp[j*4 +: 4] != 4'd0 || m_dp[j])) z = 0;
        return z;
`else
        return (slot < 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        int   slot;
        bit   tk;
        if (rst) begin
            e.an = 4'b1111; e.seg = 7'b0; e.dp = 1'b0; e.ready = 1'b1;
            m_disp = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_full = 0; n = 0;
        end else begin
            slot = (n / DIV) % 4;
            tk   = (n % DIV) == DIV - 1;
            if (blank || lead_zero(slot)) begin
                e.an = 4'b1111; e.seg = 7'b0; e.dp = 1'b0;
            end else begin
                e.an  = 4'b1111;
                e.an[slot] = 1'b0;
                e.seg = ref_enc(m_disp[slot*4 +: 4]);
                e.dp  = m_dp[slot];
            end
            if (tk && slot == 3 && m_full) begin
                m_disp = m_pend; m_dp = m_pdp; m_full = 0;
            end else if (din_valid && !m_full) begin
                m_pend = din; m_pdp = dp_in; m_full = 1;
            end
            e.ready = !m_full;
            n = (n + 1) % (4 * DIV);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("an", 16'(an), 16'(e.an));
        check("seg", 16'(seg), 16'(e.seg));
        check("dp", 16'(dp), 16'(e.dp));
        check("din_ready", 16'(din_ready), 16'(e.ready));
        check("an_onehot", 16'($countones(~an) <= 1), 16'd1);
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    // Holds valid until the bench model sees the transfer; valid is left high for the caller.
    task automatic offer(input logic [15:0] d, input logic [3:0] p);
        bit done = 0;
        din = d; dp_in = p; din_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            done = !m_full;
            step();
        end
        check("accept_within_budget", 16'(done), 16'd1);
    endtask

    task automatic wait_pos(input int pos);
        for (int k = 0; k < 4 * DIV && n != pos; k++) step();
        check("reach_frame_pos", 16'(n), 16'(pos));
    endtask

    initial begin
        rst = 1'b1; din = '0; dp_in = '0; din_valid = 1'b0; blank = 1'b0;
        n = 0; m_disp = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_full = 0;
        run(3);
        rst = 1'b0;
        run(32);

        // Single-cycle offer mid-frame.
        wait_pos(6);
        din = 16'h1234; dp_in = 4'b0000; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        run(40);

        // Back-to-back offers with valid held: second waits for the drain.
        offer(16'h5678, 4'b0000);
        offer(16'h9999, 4'b0000);
        din_valid = 1'b0;
        run(40);

        // Non-BCD codes and leading zeros.
        offer(16'h00AF, 4'b0000);
        din_valid = 1'b0;
        run(36);

        // Decimal points, including one that defeats leading-zero blanking.
        offer(16'h0005, 4'b0101);
        din_valid = 1'b0;
        run(36);

        // Three-cycle blank pulse inside the digit2 slot.
        wait_pos(2 * DIV);
        blank = 1'b1;
        run(3);
        blank = 1'b0;
        run(20);

        // Reset mid-frame with the pending buffer full.
        wait_pos(1);
        din = 16'h4321; dp_in = 4'b1111; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        run(3);
        check("pending_full_before_reset", 16'(din_ready), 16'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
